// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to a variable-latency memory,
// buffers in-order responses and hands {PC, word} to decode; redirects discard stale words.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_PC,
  output logic [31:0] out_instruction,
  output logic        misaligned_fault
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          fault;

  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_data [QUEUE_DEPTH];

  logic          pop;
  logic          accept;
  logic          enq;
  logic [CW:0]   credit;
  logic [CW-1:0] outstanding_nxt;

  assign out_valid        = (count != '0);
  assign imem_req_addr    = fetch_pc;
  assign misaligned_fault = fault;
  // Zero when empty so nothing stale or uninitialised is visible to decode.
  assign out_PC           = out_valid ? q_pc[head]   : '0;
  assign out_instruction  = out_valid ? q_data[head] : '0;

  // Credit: in-flight requests plus buffered words may never exceed the queue.
  always_comb begin
    pop             = out_valid && out_ready;
    credit          = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
    imem_req_valid  = !reset && !fault && (credit < (CW+1)'(QUEUE_DEPTH));
    accept          = imem_req_valid && imem_req_ready;
    enq             = imem_resp_valid && (drop == '0);
    outstanding_nxt = outstanding + CW'(accept) - CW'(imem_resp_valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      fault       <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        drop     <= outstanding_nxt;
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        fault    <= |redirect_target[1:0];
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
        if (enq) begin
          tail    <= tail + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) head <= head + PW'(1);
        count <= count + CW'(enq) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !redirect_valid && enq) begin
      q_pc[tail]   <= resp_pc;
      q_data[tail] <= imem_resp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(enq && !redirect_valid && !pop && (count == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order variable-latency memory model plus a stream
// scoreboard (sequential PCs from reset/redirect target, word = PC + 0x1000).
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_PC;
  logic [31:0] out_instruction;
  logic        misaligned_fault;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_PC          (out_PC),
    .out_instruction (out_instruction),
    .misaligned_fault(misaligned_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    int          lat;
    int          pre;
    logic [31:0] target;
    logic        exp_fault;
    logic [31:0] exp_first_pc;
    logic [31:0] exp_first_instr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  mreq_t       mem_q[$];
  logic [31:0] popped[$];
  int          mem_lat = 1;
  int          cyc = 0;
  int          accepts = 0;
  int          pops = 0;
  int          first_valid_cyc = -1;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req_pc = '0;
  logic        fault_exp = 1'b0;
  bit          redir_prev = 1'b0;
  bit          first_seen = 1'b0;
  logic [31:0] first_pc = '0;
  logic [31:0] first_instr = '0;
  vec_t        vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h0000_1000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input bit rv, input logic [31:0] tgt, input bit ordy,
                      input bit rrdy, input bit rst);
    mreq_t m;
    reset           = rst;
    redirect_valid  = rv;
    redirect_target = tgt;
    out_ready       = ordy;
    imem_req_ready  = rrdy;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom();
    end
    #1;
    if (!rst) begin
      chk("fault_flag", misaligned_fault, fault_exp);
      if (fault_exp || redir_prev) chk("out_valid_quiet", out_valid, 1'b0);
      if (fault_exp) chk("req_valid_in_fault", imem_req_valid, 1'b0);
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        chk("out_pc", out_PC, exp_pc);
        chk("out_instr", out_instruction, mem_word(exp_pc));
        if (!first_seen) begin
          first_seen  = 1'b1;
          first_pc    = out_PC;
          first_instr = out_instruction;
        end
        popped.push_back(out_PC);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (imem_req_valid && imem_req_ready) begin
        m.addr = imem_req_addr;
        m.due  = cyc + mem_lat;
        mem_q.push_back(m);
        exp_req_pc = exp_req_pc + 32'd4;
        accepts++;
      end
      if (rv) begin
        exp_pc     = tgt;
        exp_req_pc = tgt;
        fault_exp  = |tgt[1:0];
        first_seen = 1'b0;
        popped.delete();
      end
      redir_prev = rv;
      cyc++;
    end else begin
      mem_q.delete();
      popped.delete();
      exp_pc          = 32'h0;
      exp_req_pc      = 32'h0;
      fault_exp       = 1'b0;
      redir_prev      = 1'b0;
      first_seen      = 1'b0;
      first_valid_cyc = -1;
      accepts         = 0;
      pops            = 0;
      cyc             = 1;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_PC, 32'h0);
    chk("rst_out_instr", out_instruction, 32'h0);
    chk("rst_fault", misaligned_fault, 1'b0);
  endtask

  task automatic wait_first(input string name);
    int n = 0;
    while (!first_seen && n < 30) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    if (!first_seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no delivery within 30 cycles", name);
    end
  endtask

  initial begin
    vecs[0] = '{3, 2, 32'h0000_0200, 1'b0, 32'h0000_0200, 32'h0000_1200};
    vecs[1] = '{1, 6, 32'h0000_0080, 1'b0, 32'h0000_0080, 32'h0000_1080};
    vecs[2] = '{2, 5, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 32'h0000_0FF8};
    vecs[3] = '{1, 4, 32'h0000_0102, 1'b1, 32'h0,         32'h0};
    vecs[4] = '{4, 3, 32'h0000_003C, 1'b0, 32'h0000_003C, 32'h0000_103C};
    vecs[5] = '{2, 0, 32'h0000_0040, 1'b0, 32'h0000_0040, 32'h0000_1040};

    @(negedge clock);

    // 1-cycle memory, streaming.
    do_reset();
    mem_lat = 1;
    repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("first_valid_cycle", first_valid_cyc, 3);
    chk("steady_pops", pops, 8);

    // Back-pressure fills exactly the queue, then drains in order.
    do_reset();
    mem_lat = 1;
    repeat (10) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bp_accepts", accepts, 4);
    chk("bp_req_valid", imem_req_valid, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    if (popped.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("bp_drain_pc", popped[i], 32'(i * 4));
    end else begin
      checks++;
      errors++;
      $display("FAIL bp_drain_count: got %0d expected >= 4", popped.size());
    end

    // Redirect table.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      mem_lat = vecs[v].lat;
      repeat (vecs[v].pre) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      step(1'b1, vecs[v].target, 1'b1, 1'b1, 1'b0);
      chk("vec_fault", misaligned_fault, vecs[v].exp_fault);
      if (vecs[v].exp_fault) begin
        repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("vec_fault_no_delivery", first_seen, 1'b0);
      end else begin
        wait_first("vec_first_timeout");
        chk("vec_first_pc", first_pc, vecs[v].exp_first_pc);
        chk("vec_first_instr", first_instr, vecs[v].exp_first_instr);
      end
    end

    // Misaligned redirect, then recovery with an aligned one.
    do_reset();
    mem_lat = 2;
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0102, 1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("mis_fault", misaligned_fault, 1'b1);
    chk("mis_req_valid", imem_req_valid, 1'b0);
    chk("mis_out_valid", out_valid, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
    chk("mis_fault_cleared", misaligned_fault, 1'b0);
    wait_first("mis_recover_timeout");
    chk("mis_recover_pc", first_pc, 32'h0000_0100);
    chk("mis_recover_instr", first_instr, 32'h0000_1100);

    // Wrap past the top of the address space.
    do_reset();
    mem_lat = 1;
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0);
    repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    if (popped.size() >= 3) begin
      chk("wrap_pc0", popped[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", popped[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", popped[2], 32'h0000_0000);
    end else begin
      checks++;
      errors++;
      $display("FAIL wrap_count: got %0d expected >= 3", popped.size());
    end

    // Random traffic against the stream scoreboard.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          rv;
      bit          rst;
      logic [31:0] tgt;
      int          kind;
      mem_lat = $urandom_range(1, 4);
      rv      = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      kind    = $urandom_range(0, 9);
      if (kind == 0)      tgt = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (kind == 1) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else                tgt = $urandom() & 32'hFFFF_FFFC;
      step(rv, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
